// File: rtl/alu_seq_if.sv
// Request/result bundle between the datapath control FSM and alu_seq.
// Latency: n/a (wires only).
// Backpressure: the master holds start until it sees busy=0; start is ignored while busy.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [2:0]       funSel;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;
    logic [3:0]       flags;

    modport master (
        output start, funSel, X, Y,
        input  busy, done, Z, flags
    );

    modport slave (
        input  start, funSel, X, Y,
        output busy, done, Z, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: add/sub/transfer/logic in one cycle, unsigned shift-and-add multiply iteratively.
// Latency: 1 cycle for funSel 000-110, WIDTH cycles for MUL; done pulses when Z/flags update.
// Backpressure: start is accepted only while busy=0; requests during a multiply are dropped.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_TRX = 3'b010;
    localparam logic [2:0] OP_NTX = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic [WIDTH-1:0]     z_q, z_nxt;
    logic [3:0]           flags_q, flags_nxt;
    logic                 done_q, done_nxt;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     res;
    logic                 c_f, v_f;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 mul_ovf;

    // Single-cycle result path, evaluated on the live operands at the accept edge.
    always_comb begin
        sum = '0;
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        case (bus.funSel)
            OP_ADD: begin
                sum = {1'b0, bus.X} + {1'b0, bus.Y};
                res = sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = (bus.X[WIDTH-1] == bus.Y[WIDTH-1]) && (res[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, bus.X} + {1'b0, ~bus.Y} + (WIDTH+1)'(1);
                res = sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = (bus.X[WIDTH-1] != bus.Y[WIDTH-1]) && (res[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_TRX:  res = bus.X;
            OP_NTX:  res = ~bus.X;
            OP_AND:  res = bus.X & bus.Y;
            OP_OR:   res = bus.X | bus.Y;
            OP_XOR:  res = bus.X ^ bus.Y;
            default: res = '0;
        endcase
    end

    // Partial product of the current iteration, folded into Z on the last one.
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_ovf  = (acc_step[2*WIDTH-1:WIDTH] != '0);

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        acc_nxt    = acc;
        mplier_nxt = mplier;
        count_nxt  = count;
        z_nxt      = z_q;
        flags_nxt  = flags_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.funSel == OP_MUL) begin
                        mcand_nxt  = {{WIDTH{1'b0}}, bus.X};
                        mplier_nxt = bus.Y;
                        acc_nxt    = '0;
                        count_nxt  = '0;
                        state_nxt  = MUL;
                    end else begin
                        z_nxt     = res;
                        flags_nxt = {res[WIDTH-1], v_f, c_f, (res == '0)};
                        done_nxt  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                count_nxt  = count + 1'b1;
                if (count == CNT_W'(WIDTH-1)) begin
                    z_nxt     = acc_step[WIDTH-1:0];
                    flags_nxt = {acc_step[WIDTH-1], mul_ovf, mul_ovf, (acc_step[WIDTH-1:0] == '0)};
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            z_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            mcand   <= mcand_nxt;
            acc     <= acc_nxt;
            mplier  <= mplier_nxt;
            count   <= count_nxt;
            z_q     <= z_nxt;
            flags_q <= flags_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.busy  = (state == MUL);
    assign bus.done  = done_q;
    assign bus.Z     = z_q;
    assign bus.flags = flags_q;
endmodule
